// File: rtl/fifo_tx_reader.sv
// Drain side of the byte FIFO: reads a frame length, pops that many bytes one
// strobe pulse at a time, and serializes each byte onto a bit valid/ready stream.
module fifo_tx_reader #(
  parameter int DATA_W    = 8,
  parameter int HOLD_CYC  = 2,
  parameter int GAP_CYC   = 3,
  parameter int LSB_FIRST = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              fifo_length_rd_en,
  input  logic [DATA_W-1:0] fifo_length_in,
  output logic              fifo_rd_en,
  input  logic [DATA_W-1:0] fifo_data_in,
  output logic              tx_bit,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] byte_cnt
);

  localparam int IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int TW = 16;
  localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_W - 1);
  localparam logic [TW-1:0] HOLD_LAST = TW'(HOLD_CYC - 1);
  localparam logic [TW-1:0] GAP_LAST  = TW'(GAP_CYC - 1);

  typedef enum logic [2:0] {IDLE, LEN, RD_HI, RD_LO, SHIFT, DONE} state_t;

  state_t            state, state_nxt;
  logic [TW-1:0]     tmr;
  logic [IW-1:0]     bit_idx, msb_idx;
  logic [DATA_W-1:0] len_q, byte_q, cnt_q, cnt_inc;
  logic              accept, last_bit, hold_end, gap_end;

  assign accept   = tx_valid & tx_ready;
  assign last_bit = (bit_idx == IDX_LAST);
  assign hold_end = (tmr == HOLD_LAST);
  assign gap_end  = (tmr == GAP_LAST);
  assign cnt_inc  = cnt_q + DATA_W'(1);
  assign msb_idx  = IDX_LAST - bit_idx;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = LEN;
      LEN:     state_nxt = (fifo_length_in == '0) ? DONE : RD_HI;
      RD_HI:   if (hold_end) state_nxt = RD_LO;
      RD_LO:   if (gap_end) state_nxt = SHIFT;
      SHIFT:   if (accept && last_bit) state_nxt = (cnt_inc == len_q) ? DONE : RD_HI;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= IDLE;
      tmr               <= '0;
      bit_idx           <= '0;
      len_q             <= '0;
      byte_q            <= '0;
      cnt_q             <= '0;
      fifo_length_rd_en <= 1'b0;
      fifo_rd_en        <= 1'b0;
      tx_valid          <= 1'b0;
      busy              <= 1'b0;
      done              <= 1'b0;
    end else begin
      state <= state_nxt;
      // tmr counts cycles spent in the current state; restarts on every transition
      tmr   <= (state_nxt != state) ? '0 : tmr + TW'(1);
      case (state)
        LEN: begin
          len_q <= fifo_length_in;
          cnt_q <= '0;
        end
        RD_HI: if (hold_end) byte_q <= fifo_data_in;
        SHIFT: if (accept) begin
          bit_idx <= last_bit ? '0 : bit_idx + IW'(1);
          if (last_bit) cnt_q <= cnt_inc;
        end
        default: ;
      endcase
      // strobes come straight from flops so the FIFO never sees decode glitches
      fifo_length_rd_en <= (state_nxt == LEN);
      fifo_rd_en        <= (state_nxt == RD_HI);
      tx_valid          <= (state_nxt == SHIFT);
      busy              <= (state_nxt != IDLE);
      done              <= (state_nxt == DONE);
    end
  end

  assign tx_bit   = tx_valid & ((LSB_FIRST != 0) ? byte_q[bit_idx] : byte_q[msb_idx]);
  assign byte_cnt = cnt_q;

endmodule

// File: tb/tb_fifo_tx_reader.sv
// Bench for fifo_tx_reader: a FIFO model feeds bytes, a monitor records the
// pop pulses and the accepted bit stream, and each frame is checked against the bytes.
module tb_fifo_tx_reader;
  localparam int DW = 8, H = 2, G = 3;

  logic clk = 1'b0;
  logic reset, start, tx_ready;
  logic fifo_length_rd_en, fifo_rd_en, tx_bit, tx_valid, busy, done;
  logic [DW-1:0] fifo_length_in, fifo_data_in, byte_cnt;

  always #5 clk = ~clk;

  fifo_tx_reader #(.DATA_W(DW), .HOLD_CYC(H), .GAP_CYC(G), .LSB_FIRST(1)) dut (
    .clk(clk), .reset(reset), .start(start),
    .fifo_length_rd_en(fifo_length_rd_en), .fifo_length_in(fifo_length_in),
    .fifo_rd_en(fifo_rd_en), .fifo_data_in(fifo_data_in),
    .tx_bit(tx_bit), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .done(done), .byte_cnt(byte_cnt)
  );

  int tests = 0, fails = 0, cyc = 0;
  logic [DW-1:0] fq[$];
  int head;
  bit got[$];
  int pops, len_strb, done_cnt, pulse_bad, stab_err, hi_run, lo_run;
  int t_len, t_rd, t_tx, t_done;
  logic prev_rd, prev_stall, prev_bit;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Monitor on the falling edge: inputs and outputs seen here are what the next rising edge samples.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (tx_valid && tx_ready) got.push_back(tx_bit);
      if (prev_stall && (!tx_valid || tx_bit !== prev_bit)) stab_err++;
      prev_stall = tx_valid && !tx_ready;
      prev_bit   = tx_bit;
      if (fifo_length_rd_en) begin
        len_strb++;
        if (t_len < 0) t_len = cyc;
      end
      if (fifo_rd_en) begin
        if (!prev_rd && pops > 0 && lo_run < G) pulse_bad++;
        hi_run++;
        if (t_rd < 0) t_rd = cyc;
      end else begin
        if (prev_rd) begin
          pops++;
          if (hi_run != H) pulse_bad++;
          hi_run = 0;
          lo_run = 0;
          head++;
          fifo_data_in = (head < fq.size()) ? fq[head] : 8'h00;
        end
        lo_run++;
      end
      if (tx_valid && t_tx < 0) t_tx = cyc;
      if (done) begin
        done_cnt++;
        if (t_done < 0) t_done = cyc;
      end
      prev_rd = fifo_rd_en;
    end
  end

  task automatic clear();
    got.delete();
    pops = 0; len_strb = 0; done_cnt = 0; pulse_bad = 0; stab_err = 0;
    hi_run = 0; lo_run = 0; head = 0;
    t_len = -1; t_rd = -1; t_tx = -1; t_done = -1;
    prev_rd = 1'b0; prev_stall = 1'b0; prev_bit = 1'b0;
    fifo_data_in = (fq.size() > 0) ? fq[0] : 8'h00;
  endtask

  // rmode 0: ready always high, 1: random ready, 2: 20-cycle stall after 3 bits
  task automatic run_frame(input int len, input int rmode, input bit restart);
    bit exp_bits[$];
    int t0, st, nbad;
    bit seen;
    logic [DW-1:0] b;
    fifo_length_in = DW'(len);
    clear();
    for (int i = 0; i < len; i++) begin
      b = fq[i];
      for (int k = 0; k < DW; k++) exp_bits.push_back(b[k]);
    end
    st = 0; seen = 0;
    @(posedge clk); #1;
    start = 1'b1; t0 = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_start", busy, 1);
    for (int i = 0; i < len * 60 + 100; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin
        seen = 1;
        if (restart) start = 1'b1;
        break;
      end
      if (restart) start = (i == 15);
      case (rmode)
        0: tx_ready = 1'b1;
        1: tx_ready = 1'($urandom_range(0, 1));
        default: begin
          if (got.size() >= 3 && st < 20) begin tx_ready = 1'b0; st++; end
          else tx_ready = 1'b1;
        end
      endcase
    end
    check("done_within_budget", seen, 1);
    @(posedge clk); #1;
    start = 1'b0;
    tx_ready = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    nbad = 0;
    for (int i = 0; i < got.size() && i < exp_bits.size(); i++)
      if (got[i] !== exp_bits[i]) nbad++;
    check("done_pulses", done_cnt, 1);
    check("length_strobes", len_strb, 1);
    check("pop_count", pops, len);
    check("pop_pulse_shape", pulse_bad, 0);
    check("stall_stability", stab_err, 0);
    check("bit_count", got.size(), exp_bits.size());
    check("bit_errors", nbad, 0);
    check("byte_cnt", byte_cnt, len);
    check("busy_after_done", busy, 0);
    check("lat_len_strobe", t_len, t0 + 2);
    if (len > 0) begin
      check("lat_first_pop", t_rd, t0 + 3);
      check("lat_first_valid", t_tx, t0 + 3 + H + G);
    end else begin
      check("lat_done_len0", t_done, t0 + 3);
      check("no_pop_len0", t_rd, -1);
    end
  endtask

  task automatic fill_rand(input int n);
    fq.delete();
    for (int i = 0; i < n; i++) fq.push_back(DW'($urandom_range(0, 255)));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_len_rd"}, fifo_length_rd_en, 0);
    check({tag, "_rd_en"}, fifo_rd_en, 0);
    check({tag, "_tx_valid"}, tx_valid, 0);
    check({tag, "_tx_bit"}, tx_bit, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_byte_cnt"}, byte_cnt, 0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; tx_ready = 1'b0;
    fifo_length_in = '0; fifo_data_in = '0;
    fq.delete();
    clear();
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    reset = 1'b0;

    fq.delete();
    run_frame(0, 0, 0);

    fq = '{8'hA5};
    run_frame(1, 0, 0);

    fq = '{8'h01, 8'h80, 8'hFF};
    run_frame(3, 1, 0);

    fill_rand(2);
    run_frame(2, 2, 0);

    // reset during the second byte of a 4-byte frame
    fill_rand(4);
    fifo_length_in = 8'd4;
    clear();
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 300 && got.size() < 10; i++) begin
      @(posedge clk); #1;
      tx_ready = 1'b1;
    end
    check("mid_reset_reached_byte2", got.size(), 10);
    reset = 1'b1;
    @(posedge clk); #1;
    check_all_zero("mid_reset");
    reset = 1'b0;
    tx_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("mid_reset_no_done", done_cnt, 0);
    fill_rand(2);
    run_frame(2, 0, 0);

    fill_rand(2);
    run_frame(2, 0, 1);

    for (int r = 0; r < 3; r++) begin
      int n;
      n = $urandom_range(1, 6);
      fill_rand(n);
      run_frame(n, 1, 0);
    end

    fill_rand(255);
    run_frame(255, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
